// File: rtl/fb_pkg.sv
// fb_pkg: shared constants and the pixel FIFO entry type for fb_pixel_writer.
package fb_pkg;
  localparam int WIDTH      = 320;  // framebuffer width in pixels
  localparam int HEIGHT     = 240;  // framebuffer height in pixels
  localparam int AW         = 17;   // framebuffer address width
  localparam int FIFO_DEPTH = 4;    // pixel FIFO entries, power of two
  localparam int FRAC       = 6;    // fractional bits of Q10.6 coordinates

  // Serial lanes: x, y, color, each one 16-bit word MSB first.
  localparam int NUM_LANES  = 3;
  localparam int VEC_W      = 16;
  localparam int LANE_X     = 0;
  localparam int LANE_Y     = 1;
  localparam int LANE_C     = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   color;
  } fb_pix_t;
endpackage

// File: rtl/fb_pixel_writer_if.sv
// fb_pixel_writer_if: single-port framebuffer write bus (ready/valid).
interface fb_pixel_writer_if #(parameter int AW = fb_pkg::AW);
  logic          MEM_WE;
  logic [AW-1:0] MEM_ADDR;
  logic [15:0]   MEM_DATA;
  logic          MEM_READY;

  modport master (output MEM_WE, MEM_ADDR, MEM_DATA, input MEM_READY);
  modport slave  (input MEM_WE, MEM_ADDR, MEM_DATA, output MEM_READY);
endinterface

// File: rtl/fb_pixel_fifo.sv
// fb_pixel_fifo: synchronous FIFO of fb_pix_t with full/empty flags.
// A push on a full FIFO is taken when a pop happens in the same cycle.
module fb_pixel_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic    CLK,
  input  logic    RST,
  input  logic    push,
  input  fb_pix_t din,
  input  logic    pop,
  output fb_pix_t dout,
  output logic    full,
  output logic    empty
);
  localparam int PW = $clog2(DEPTH);

  fb_pix_t       mem [DEPTH];
  logic [PW:0]   wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[PW-1:0]];

  // Pointer update; cleared asynchronously so the FIFO is empty during reset.
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end

  // Storage; contents are only observed through a valid head, so no reset.
  always_ff @(posedge CLK)
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
endmodule

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: deserializes the rasterizer's x/y/color lanes, maps Q10.6
// coordinates to a linear framebuffer address, queues pixels and drains them
// to the write bus; acknowledges a triangle once all its pixels are written.
// Optional macro FB_CLIP_EN: drop off-screen pixels and count them in CLIP_CNT.
// Address width follows fb_pkg::AW (the FIFO entry type is sized by it).
module fb_pixel_writer #(
  parameter int WIDTH      = fb_pkg::WIDTH,
  parameter int HEIGHT     = fb_pkg::HEIGHT,
  parameter int FIFO_DEPTH = fb_pkg::FIFO_DEPTH,
  parameter int FRAC       = fb_pkg::FRAC
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      WORD_START,
  input  logic                      PIX_VALID,
  input  logic                      PX,
  input  logic                      PY,
  input  logic                      C,
  input  logic                      TRI_DONE,
  fb_pixel_writer_if.master         mem,
  output logic                      TRI_ACK,
  output logic [7:0]                DROP_CNT,
  output logic [7:0]                CLIP_CNT
);
  import fb_pkg::*;

  logic [NUM_LANES-1:0][VEC_W-1:0] sr;
  logic [NUM_LANES-1:0]            lane_in;
  logic [3:0]                      bit_cnt;
  logic                            pix_vld_lat;
  logic                            word_done;
  logic [1:0]                      vld_pipe;   // [0] word complete, [1] address stage
  logic                            addr_ok;
  logic signed [31:0]              xe, ye, xi, yi, lin;
  logic                            unused_bits;
  fb_pix_t                         pix_a, head;
  logic                            fifo_full, fifo_empty;
  logic                            tri_pend, idle;
  logic [7:0]                      drop_cnt;

  assign lane_in = {C, PY, PX};

  // All lanes shift together while a word is being received.
  always_ff @(posedge CLK or posedge RST)
    if (RST) sr <= '0;
    else if (WORD_START || bit_cnt != 4'd0)
      for (int l = 0; l < NUM_LANES; l++) sr[l] <= {sr[l][VEC_W-2:0], lane_in[l]};

  // Bit counter: WORD_START (re)starts at bit 15, an unfinished word is simply abandoned.
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      bit_cnt     <= 4'd0;
      pix_vld_lat <= 1'b0;
    end else if (WORD_START) begin
      bit_cnt     <= 4'd15;
      pix_vld_lat <= PIX_VALID;
    end else if (bit_cnt != 4'd0) begin
      bit_cnt     <= bit_cnt - 4'd1;
    end

  // Only a completed inside-triangle word enters the pipeline.
  assign word_done = !WORD_START && (bit_cnt == 4'd1) && pix_vld_lat;

  // Q10.6 -> integer pixel index (floor via arithmetic shift), then row-major address.
  assign xe  = {{16{sr[LANE_X][15]}}, sr[LANE_X]};
  assign ye  = {{16{sr[LANE_Y][15]}}, sr[LANE_Y]};
  assign xi  = xe >>> FRAC;
  assign yi  = ye >>> FRAC;
  assign lin = yi * WIDTH + xi;

`ifdef FB_CLIP_EN
  logic       in_range;
  logic [7:0] clip_cnt;

  assign in_range    = (xi >= 0) && (xi < WIDTH) && (yi >= 0) && (yi < HEIGHT);
  assign addr_ok     = in_range;
  assign unused_bits = ^lin[31:AW];
  assign CLIP_CNT    = clip_cnt;

  // Saturating count of completed pixels falling outside the framebuffer.
  always_ff @(posedge CLK or posedge RST)
    if (RST) clip_cnt <= 8'd0;
    else if (vld_pipe[0] && !in_range && clip_cnt != 8'hFF) clip_cnt <= clip_cnt + 8'd1;
`else
  // No bounds check: the address simply wraps modulo 2^AW.
  assign addr_ok     = 1'b1;
  assign unused_bits = ^{lin[31:AW], HEIGHT[0]};
  assign CLIP_CNT    = 8'd0;
`endif

  // Valid shift register plus the registered address-stage payload.
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      vld_pipe <= '0;
      pix_a    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0] && addr_ok, word_done};
      if (vld_pipe[0]) begin
        pix_a.addr  <= lin[AW-1:0];
        pix_a.color <= sr[LANE_C];
      end
    end

  fb_pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (vld_pipe[1]),
    .din   (pix_a),
    .pop   (mem.MEM_READY),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head of the FIFO is presented directly, so it holds while the memory stalls.
  assign mem.MEM_WE   = !fifo_empty;
  assign mem.MEM_ADDR = fifo_empty ? '0 : head.addr;
  assign mem.MEM_DATA = fifo_empty ? '0 : head.color;

  // Nothing deserializing, nothing in the address stage or waiting to be pushed.
  assign idle = (bit_cnt == 4'd0) && (vld_pipe == 2'b00);

  // Overflow counter and the end-of-triangle handshake (extra TRI_DONEs are absorbed).
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      drop_cnt <= 8'd0;
      tri_pend <= 1'b0;
      TRI_ACK  <= 1'b0;
    end else begin
      if (vld_pipe[1] && fifo_full && !mem.MEM_READY && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
      TRI_ACK <= 1'b0;
      if (tri_pend && fifo_empty && idle) begin
        TRI_ACK  <= 1'b1;
        tri_pend <= 1'b0;
      end else if (TRI_DONE) begin
        tri_pend <= 1'b1;
      end
    end

  assign DROP_CNT = drop_cnt;
endmodule

// File: tb/tb_fb_pixel_writer.sv
// tb_fb_pixel_writer: directed + randomized bench with a cycle-indexed
// behavioural model (scheduled pushes, queue FIFO, triangle pending flag).
module tb_fb_pixel_writer;
  logic       CLK = 1'b0, RST = 1'b1;
  logic       WORD_START = 1'b0, PIX_VALID = 1'b0, PX = 1'b0, PY = 1'b0, C = 1'b0, TRI_DONE = 1'b0;
  logic       TRI_ACK;
  logic [7:0] DROP_CNT, CLIP_CNT;

  fb_pixel_writer_if mif();

  fb_pixel_writer dut (
    .CLK        (CLK),
    .RST        (RST),
    .WORD_START (WORD_START),
    .PIX_VALID  (PIX_VALID),
    .PX         (PX),
    .PY         (PY),
    .C          (C),
    .TRI_DONE   (TRI_DONE),
    .mem        (mif),
    .TRI_ACK    (TRI_ACK),
    .DROP_CNT   (DROP_CNT),
    .CLIP_CNT   (CLIP_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct { int addr; int data; } ent_t;

  // Model state: pushes keyed by the clock edge they land on.
  ent_t q[$];
  ent_t sched[int];
  bit   clip_at[int];
  int   span_s[$], span_e[$];   // edges during which a word is still in flight
  int   pe = 0;                 // index of the most recent modelled edge
  int   m_drop = 0, m_clip = 0;
  bit   pend = 0, ack_exp = 0;

  int   checks = 0, passes = 0;
  int   rdy_mode = 1;           // 0 low, 1 high, 2 random
  bit   tri_rand = 0;
  bit   rst_drv = 1;
  ent_t wlog[$];
  int   wedge[$];
  int   n_ack = 0, ack_edge = -1, first_we = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, pe);
  endtask

  task automatic model_reset();
    q.delete(); sched.delete(); clip_at.delete();
    span_s.delete(); span_e.delete();
    m_drop = 0; m_clip = 0; pend = 0; ack_exp = 0;
  endtask

  task automatic model_edge(input int e, input bit td, input bit rdy);
    bit busy, ack;
    busy = 0;
    for (int i = span_s.size() - 1; i >= 0; i--) begin
      if (span_e[i] < e) begin span_s.delete(i); span_e.delete(i); end
      else if (e > span_s[i]) busy = 1;
    end
    ack = pend && (q.size() == 0) && !busy;
    if (q.size() > 0 && rdy) void'(q.pop_front());
    if (sched.exists(e)) begin
      if (q.size() < 4) q.push_back(sched[e]);
      else if (m_drop < 255) m_drop++;
      sched.delete(e);
    end
    if (clip_at.exists(e)) begin
      if (m_clip < 255) m_clip++;
      clip_at.delete(e);
    end
    ack_exp = ack;
    if (ack) pend = 0;
    else if (td) pend = 1;
  endtask

  task automatic compare();
    bit we_e;
    we_e = (q.size() > 0);
    chk("mem_we",   mif.MEM_WE,   we_e);
    chk("mem_addr", mif.MEM_ADDR, we_e ? q[0].addr : 0);
    chk("mem_data", mif.MEM_DATA, we_e ? q[0].data : 0);
    chk("tri_ack",  TRI_ACK,  ack_exp);
    chk("drop_cnt", DROP_CNT, m_drop);
    chk("clip_cnt", CLIP_CNT, m_clip);
    if (mif.MEM_WE === 1'b1 && first_we < 0) first_we = pe;
    if (TRI_ACK === 1'b1) begin n_ack++; ack_edge = pe; end
  endtask

  // One clock: check outputs of the last edge, drive inputs for the next, advance model.
  task automatic cycle(input bit ws, input bit pv, input bit x, input bit y, input bit c, input bit td);
    bit rdy;
    @(negedge CLK);
    compare();
    rdy = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    if (tri_rand && $urandom_range(0, 39) == 0) td = 1;
    RST = rst_drv; WORD_START = ws; PIX_VALID = pv; PX = x; PY = y; C = c; TRI_DONE = td;
    mif.MEM_READY = rdy;
    if (mif.MEM_WE === 1'b1 && rdy && !rst_drv) begin
      wlog.push_back('{int'(mif.MEM_ADDR), int'(mif.MEM_DATA)});
      wedge.push_back(pe + 1);
    end
    pe++;
    if (rst_drv) model_reset();
    else model_edge(pe, td, rdy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic send_word(input logic [15:0] x, input logic [15:0] y, input logic [15:0] c,
                           input bit v, input int nbits = 16);
    int k, en, xi, yi;
    k  = pe + 1;
    xi = $signed(x) >>> 6;
    yi = $signed(y) >>> 6;
    en = k + ((nbits == 16) ? 15 : nbits);
    if (nbits == 16 && v) begin
      en = k + 17;
`ifdef FB_CLIP_EN
      if (xi < 0 || xi >= 320 || yi < 0 || yi >= 240) begin en = k + 16; clip_at[k + 16] = 1; end
`endif
      if (en == k + 17) sched[k + 17] = '{(yi * 320 + xi) & 32'h1FFFF, int'(c)};
    end
    span_s.push_back(k); span_e.push_back(en);
    for (int i = 0; i < nbits; i++) cycle(i == 0, v, x[15 - i], y[15 - i], c[15 - i], 0);
  endtask

  function automatic logic [15:0] rnd_coord(input int lim);
    logic [15:0] v;
    if ($urandom_range(0, 3) != 0) v = 16'(($urandom_range(0, lim - 1) << 6) | $urandom_range(0, 63));
    else v = 16'($urandom);
    return v;
  endfunction

  initial begin
    int k0;
    // reset state
    rst_drv = 1; idle(3);
    rst_drv = 0; idle(2);

    // single pixel, latency and address
    rdy_mode = 1; first_we = -1; wlog.delete(); wedge.delete();
    k0 = pe + 1;
    send_word(16'h0280, 16'h0500, 16'hF800, 1); idle(6);
    chk("t1_nwr", wlog.size(), 1);
    if (wlog.size() >= 1) begin
      chk("t1_addr", wlog[0].addr, 6410);
      chk("t1_data", wlog[0].data, 32'hF800);
    end
    chk("t1_lat", first_we, k0 + 17);

    // background word
    wlog.delete();
    send_word(16'h0280, 16'h0500, 16'hF800, 0); idle(20);
    chk("t2_nwr", wlog.size(), 0);
    chk("t2_drop", DROP_CNT, 0);

    // overflow with memory stalled
    rdy_mode = 0; wlog.delete();
    for (int i = 0; i < 6; i++) send_word(16'(i << 6), 16'h0040, 16'(16'h1000 + i), 1);
    idle(8);
    chk("t3_drop", DROP_CNT, 2);
    rdy_mode = 1; idle(10);
    chk("t3_nwr", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      chk("t3_addr", wlog[i].addr, 320 + i);
      chk("t3_data", wlog[i].data, 32'h1000 + i);
    end

    // x on the right edge (320)
    wlog.delete();
    send_word(16'h5000, 16'h0500, 16'h07E0, 1); idle(6);
`ifdef FB_CLIP_EN
    chk("t4_nwr", wlog.size(), 0);
    chk("t4_clip", CLIP_CNT, 1);
`else
    chk("t4_nwr", wlog.size(), 1);
    if (wlog.size() >= 1) chk("t4_addr", wlog[0].addr, 6720);
`endif

    // triangle ack with toggling ready
    rdy_mode = 2; wlog.delete(); wedge.delete(); n_ack = 0;
    for (int i = 0; i < 3; i++) send_word(16'((10 + i) << 6), 16'h0080, 16'(16'hA000 + i), 1);
    cycle(0, 0, 0, 0, 0, 1);
    idle(100);
    chk("t5_nack", n_ack, 1);
    chk("t5_nwr", wlog.size(), 3);
    if (wedge.size() >= 3) chk("t5_after_last", ack_edge > wedge[2], 1);

    // reset mid-word with two queued pixels
    rdy_mode = 0;
    send_word(16'h0040, 16'h0040, 16'h1111, 1);
    send_word(16'h0080, 16'h0040, 16'h2222, 1);
    idle(3);
    send_word(16'h00C0, 16'h0040, 16'h3333, 1, 5);
    #2 RST = 1'b1; rst_drv = 1;
    #1 chk("t6_we_async", mif.MEM_WE, 0);
    model_reset();
    idle(3);
    rst_drv = 0; rdy_mode = 1; wlog.delete();
    idle(30);
    chk("t6_nwr", wlog.size(), 0);

    // randomized traffic
    rdy_mode = 2; tri_rand = 1;
    for (int n = 0; n < 250; n++) begin
      idle($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)
        send_word(16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(1, 15));
      send_word(rnd_coord(320), rnd_coord(240), 16'($urandom), $urandom_range(0, 3) != 0);
    end
    tri_rand = 0; rdy_mode = 1;
    idle(60);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
